// File: rtl/subleq_run_ctrl.sv
// Run/step/stop sequencer for a SUBLEQ core: gates the core clock enable on
// instruction boundaries, counts retired instructions and records halt causes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | core parked at operand fetch, waiting for a host command
// RUN    | free-running until NEG_PC, instruction limit or STOP
// STEP   | executing exactly one instruction
// DRAIN  | STOP seen mid-instruction, finishing the current one
// HALTED | core jumped to a negative address; only CLEAR leaves
module subleq_run_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic [31:0] run_limit,
    input  logic        core_pc_ld,
    input  logic [15:0] core_pc_next,
    output logic        core_en,
    output logic        core_rst,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] insn_count,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_STOP  = 2'b01;
    localparam logic [1:0] C_NEGPC = 2'b10;
    localparam logic [1:0] C_LIMIT = 2'b11;

    state_t      state_q, state_d;
    logic        core_en_q, core_en_d;
    logic        core_rst_q, core_rst_d;
    logic        rst_hold_q, rst_hold_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] insn_count_q, insn_count_d;
    logic [31:0] limit_q, limit_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic        done_q, done_d;

    logic        accept;
    logic        retire;
    logic        neg_pc;
    logic        do_clear;
    logic [31:0] run_cnt_inc;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^core_pc_next[14:0];

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_IDLE:   cmd_ready = 1'b1;
            S_RUN:    begin cmd_ready = 1'b1; busy = 1'b1; end
            S_STEP:   busy = 1'b1;
            S_DRAIN:  busy = 1'b1;
            S_HALTED: begin cmd_ready = 1'b1; halted = 1'b1; end
            default:  ;
        endcase
    end

    assign accept      = cmd_valid && cmd_ready;
    assign retire      = core_pc_ld && core_en_q;
    assign neg_pc      = core_pc_next[15];
    assign run_cnt_inc = run_cnt_q + 32'd1;

    always_comb begin
        state_d      = state_q;
        core_en_d    = core_en_q;
        core_rst_d   = rst_hold_q;   // stretches reset to the core by one cycle
        rst_hold_d   = 1'b0;
        cause_d      = cause_q;
        insn_count_d = insn_count_q;
        limit_d      = limit_q;
        run_cnt_d    = run_cnt_q;
        done_d       = 1'b0;
        do_clear     = 1'b0;

        if (retire && (insn_count_q != 32'hFFFF_FFFF)) begin
            insn_count_d = insn_count_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                core_en_d = 1'b0;
                if (accept) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_d   = S_RUN;
                            core_en_d = 1'b1;
                            limit_d   = run_limit;
                            run_cnt_d = 32'd0;
                            cause_d   = C_NONE;
                        end
                        OP_STEP: begin
                            state_d   = S_STEP;
                            core_en_d = 1'b1;
                            cause_d   = C_NONE;
                        end
                        OP_CLEAR: do_clear = 1'b1;
                        default:  ;
                    endcase
                end
            end
            S_RUN: begin
                if (retire) begin
                    run_cnt_d = run_cnt_inc;
                end
                // A STOP arriving on the terminating retire is dropped.
                if (retire && neg_pc) begin
                    state_d   = S_HALTED;
                    cause_d   = C_NEGPC;
                    core_en_d = 1'b0;
                    done_d    = 1'b1;
                end else if (retire && (limit_q != 32'd0) && (run_cnt_inc == limit_q)) begin
                    state_d   = S_IDLE;
                    cause_d   = C_LIMIT;
                    core_en_d = 1'b0;
                    done_d    = 1'b1;
                end else if (accept && (cmd_op == OP_STOP)) begin
                    state_d = S_DRAIN;
                end
            end
            S_STEP, S_DRAIN: begin
                if (retire) begin
                    core_en_d = 1'b0;
                    done_d    = 1'b1;
                    if (neg_pc) begin
                        state_d = S_HALTED;
                        cause_d = C_NEGPC;
                    end else begin
                        state_d = S_IDLE;
                        cause_d = (state_q == S_DRAIN) ? C_STOP : C_NONE;
                    end
                end
            end
            S_HALTED: begin
                core_en_d = 1'b0;
                if (accept && (cmd_op == OP_CLEAR)) begin
                    do_clear = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                core_en_d = 1'b0;
            end
        endcase

        if (do_clear) begin
            state_d      = S_IDLE;
            insn_count_d = 32'd0;
            cause_d      = C_NONE;
            core_rst_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            core_en_q    <= 1'b0;
            core_rst_q   <= 1'b1;
            rst_hold_q   <= 1'b1;
            cause_q      <= C_NONE;
            insn_count_q <= 32'd0;
            limit_q      <= 32'd0;
            run_cnt_q    <= 32'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_en_q    <= core_en_d;
            core_rst_q   <= core_rst_d;
            rst_hold_q   <= rst_hold_d;
            cause_q      <= cause_d;
            insn_count_q <= insn_count_d;
            limit_q      <= limit_d;
            run_cnt_q    <= run_cnt_d;
            done_q       <= done_d;
        end
    end

    assign core_en    = core_en_q;
    assign core_rst   = core_rst_q;
    assign halt_cause = cause_q;
    assign insn_count = insn_count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_subleq_run_ctrl.sv
// Directed vector bench for subleq_run_ctrl: per-edge table plus a
// multi-cycle limited run with gapped retires.
module tb_subleq_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic [31:0] run_limit;
    logic        core_pc_ld;
    logic [15:0] core_pc_next;
    logic        core_en;
    logic        core_rst;
    logic        busy;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] insn_count;
    logic        done;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] RUN = 2'b00, STEP = 2'b01, STOP = 2'b10, CLR = 2'b11;

    subleq_run_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_ready    (cmd_ready),
        .run_limit    (run_limit),
        .core_pc_ld   (core_pc_ld),
        .core_pc_next (core_pc_next),
        .core_en      (core_en),
        .core_rst     (core_rst),
        .busy         (busy),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .insn_count   (insn_count),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [1:0]  op;
        logic [31:0] lim;
        logic        ld;
        logic [15:0] pc;
        logic        en;
        logic        crst;
        logic        busy;
        logic        hlt;
        logic [1:0]  cause;
        logic [31:0] cnt;
        logic        done;
        logic        rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic [1:0] o, input logic [31:0] l,
                       input logic ld, input logic [15:0] pc,
                       input logic en, input logic crst, input logic bsy, input logic hlt,
                       input logic [1:0] cause, input logic [31:0] cnt, input logic dn,
                       input logic rdy);
        vec_t e;
        e.rst = r; e.vld = v; e.op = o; e.lim = l; e.ld = ld; e.pc = pc;
        e.en = en; e.crst = crst; e.busy = bsy; e.hlt = hlt; e.cause = cause;
        e.cnt = cnt; e.done = dn; e.rdy = rdy;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        int retires;
        bit done_seen;
        logic [31:0] base_cnt;

        //  rst vld op    lim ld pc        en crst bsy hlt cause cnt done rdy
        add(1, 0, RUN,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 0, RUN,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, RUN,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, RUN,  0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1);
        // limited run of 3
        add(0, 1, RUN,  3, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, RUN,  0, 1, 16'h0003, 1, 0, 1, 0, 0, 1, 0, 1);
        add(0, 0, RUN,  0, 0, 16'h0000, 1, 0, 1, 0, 0, 1, 0, 1);
        add(0, 0, RUN,  0, 1, 16'h0006, 1, 0, 1, 0, 0, 2, 0, 1);
        add(0, 0, RUN,  0, 1, 16'h0009, 0, 0, 0, 0, 3, 3, 1, 1);
        add(0, 0, RUN,  0, 1, 16'h0005, 0, 0, 0, 0, 3, 3, 0, 1);
        // single step
        add(0, 1, STEP, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 3, 0, 0);
        add(0, 1, RUN,  0, 0, 16'h0000, 1, 0, 1, 0, 0, 3, 0, 0);
        add(0, 0, RUN,  0, 1, 16'h0010, 0, 0, 0, 0, 0, 4, 1, 1);
        // negative PC halt, ignored commands, clear
        add(0, 1, RUN,  0, 0, 16'h0000, 1, 0, 1, 0, 0, 4, 0, 1);
        add(0, 0, RUN,  0, 1, 16'h8000, 0, 0, 0, 1, 2, 5, 1, 1);
        add(0, 1, RUN,  0, 0, 16'h0000, 0, 0, 0, 1, 2, 5, 0, 1);
        add(0, 1, STEP, 0, 0, 16'h0000, 0, 0, 0, 1, 2, 5, 0, 1);
        add(0, 1, CLR,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, RUN,  0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1);
        // stop mid-instruction drains
        add(0, 1, RUN,  0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 1);
        add(0, 1, STOP, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, RUN,  0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, RUN,  0, 1, 16'h0020, 0, 0, 0, 0, 1, 1, 1, 1);
        // limit beats STOP on the same edge
        add(0, 1, RUN,  1, 0, 16'h0000, 1, 0, 1, 0, 0, 1, 0, 1);
        add(0, 1, STOP, 0, 1, 16'h0004, 0, 0, 0, 0, 3, 2, 1, 1);
        add(0, 0, RUN,  0, 0, 16'h0000, 0, 0, 0, 0, 3, 2, 0, 1);
        // NEG_PC beats limit and STOP
        add(0, 1, RUN,  1, 0, 16'h0000, 1, 0, 1, 0, 0, 2, 0, 1);
        add(0, 1, STOP, 0, 1, 16'h8004, 0, 0, 0, 1, 2, 3, 1, 1);
        add(0, 1, CLR,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 1);
        // STOP on a non-terminal retire, then drain ends at negative PC
        add(0, 1, RUN,  5, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 1);
        add(0, 1, STOP, 0, 1, 16'h0001, 1, 0, 1, 0, 0, 1, 0, 0);
        add(0, 0, RUN,  0, 1, 16'h8008, 0, 0, 0, 1, 2, 2, 1, 1);
        add(0, 1, CLR,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, RUN,  0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1);
        // reset mid-run
        add(0, 1, RUN,  0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, RUN,  0, 1, 16'h0002, 1, 0, 1, 0, 0, 1, 0, 1);
        add(1, 0, RUN,  0, 1, 16'h0003, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, RUN,  0, 1, 16'h0004, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, RUN,  0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1);
        // STOP in IDLE is a no-op; RUN during RUN does not relatch limit
        add(0, 1, STOP, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, RUN,  2, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 1);
        add(0, 1, RUN,  9, 1, 16'h0001, 1, 0, 1, 0, 0, 1, 0, 1);
        add(0, 0, RUN,  0, 1, 16'h0002, 0, 0, 0, 0, 3, 2, 1, 1);

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = RUN; run_limit = '0;
        core_pc_ld = 1'b0; core_pc_next = '0;

        for (int i = 0; i < tbl.size(); i++) begin
            rst          = tbl[i].rst;
            cmd_valid    = tbl[i].vld;
            cmd_op       = tbl[i].op;
            run_limit    = tbl[i].lim;
            core_pc_ld   = tbl[i].ld;
            core_pc_next = tbl[i].pc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_core_en", i),    {31'd0, core_en},    {31'd0, tbl[i].en});
            chk($sformatf("v%0d_core_rst", i),   {31'd0, core_rst},   {31'd0, tbl[i].crst});
            chk($sformatf("v%0d_busy", i),       {31'd0, busy},       {31'd0, tbl[i].busy});
            chk($sformatf("v%0d_halted", i),     {31'd0, halted},     {31'd0, tbl[i].hlt});
            chk($sformatf("v%0d_halt_cause", i), {30'd0, halt_cause}, {30'd0, tbl[i].cause});
            chk($sformatf("v%0d_insn_count", i), insn_count,          tbl[i].cnt);
            chk($sformatf("v%0d_done", i),       {31'd0, done},       {31'd0, tbl[i].done});
            chk($sformatf("v%0d_cmd_ready", i),  {31'd0, cmd_ready},  {31'd0, tbl[i].rdy});
        end
        base_cnt = tbl[tbl.size()-1].cnt;

        // Limit-7 run with retires on alternate cycles; bounded wait for done.
        rst = 1'b0; core_pc_ld = 1'b0;
        cmd_valid = 1'b1; cmd_op = RUN; run_limit = 32'd7;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        retires = 0;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
            core_pc_ld   = (cyc % 2 == 0);
            core_pc_next = 16'(cyc);
            if (core_pc_ld && core_en) retires++;
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        core_pc_ld = 1'b0;
        chk("seq_done_seen",  {31'd0, done_seen}, 32'd1);
        chk("seq_retires",    32'(retires),       32'd7);
        chk("seq_insn_count", insn_count,         base_cnt + 32'd7);
        chk("seq_halt_cause", {30'd0, halt_cause}, 32'd3);
        chk("seq_core_en",    {31'd0, core_en},   32'd0);
        chk("seq_busy",       {31'd0, busy},      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/subleq_run_ctrl.md
SUBLEQ_RUN_CTRL -- requirements
Module: subleq_run_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 cmd_valid  input  1  host command strobe.
REQ-004 cmd_op  input  2  00 RUN, 01 STEP, 10 STOP, 11 CLEAR.
REQ-005 cmd_ready  output  1  command accepted on the edge where cmd_valid && cmd_ready.
REQ-006 run_limit  input  32  instruction budget for a RUN, sampled at RUN accept; 0 means unlimited.
REQ-007 core_pc_ld  input  1  core retire strobe, high during the core's writeback/PC-update cycle.
REQ-008 core_pc_next  input  16  PC value being loaded at retire; bit 15 set means a negative address, which is the halt target.
REQ-009 core_en  output  1  registered; the core FSM advances only on edges where core_en = 1.
REQ-010 core_rst  output  1  registered synchronous reset to the core; forces the core to its operand-fetch state.
REQ-011 busy  output  1  high in the RUN, STEP and DRAIN states.
REQ-012 halted  output  1  high in the HALTED state.
REQ-013 halt_cause  output  2  00 none, 01 STOP, 10 NEG_PC, 11 LIMIT.
REQ-014 insn_count  output  32  instructions retired since the last CLEAR or reset.
REQ-015 done  output  1  one-cycle pulse on entry to IDLE or HALTED from RUN, STEP or DRAIN.

Function
REQ-016 States: IDLE, RUN, STEP, DRAIN, HALTED, encoded in 3 bits; any illegal encoding returns to IDLE on the next edge.
REQ-017 retire = core_pc_ld && core_en; all counting and stop decisions are made on the retire edge only.
REQ-018 core_en is cleared on the retire edge whenever the next state is not RUN, so the core parks at operand fetch; the instruction boundary is never broken.
REQ-019 cmd_ready = 1 in IDLE, RUN and HALTED; 0 in STEP and DRAIN.
REQ-020 IDLE: RUN -> RUN, latches run_limit, clears the run counter, core_en <= 1; STEP -> STEP, core_en <= 1; STOP is a no-op; CLEAR -> REQ-025.
REQ-021 RUN: STOP -> DRAIN with core_en held at 1; RUN, STEP and CLEAR are accepted and ignored.
REQ-022 RUN retire: the 32-bit run counter increments.
- core_pc_next[15] = 1 -> HALTED, cause NEG_PC.
- Otherwise, latched limit != 0 and the incremented run counter == limit -> IDLE, cause LIMIT.
- Otherwise remain in RUN.
REQ-023 STEP retire: core_pc_next[15] = 1 -> HALTED with cause NEG_PC; otherwise -> IDLE with cause 00.
REQ-024 DRAIN retire: core_pc_next[15] = 1 -> HALTED with cause NEG_PC; otherwise -> IDLE with cause STOP.
REQ-025 CLEAR, accepted in IDLE or HALTED:
- next state IDLE;
- insn_count <= 0, halt_cause <= 00;
- core_rst <= 1 for exactly one cycle;
- done is not pulsed.
REQ-026 HALTED: only CLEAR changes state; RUN, STEP and STOP are accepted and ignored.
REQ-027 Simultaneous stop conditions resolve with priority NEG_PC > LIMIT > STOP.
- A STOP accepted on a RUN retire edge that ends the run is dropped.
- A STOP accepted on a non-terminal RUN retire edge goes to DRAIN, and the next retire applies REQ-024.
REQ-028 insn_count increments on every retire and saturates at 0xFFFF_FFFF.
REQ-029 halt_cause is written when entering IDLE or HALTED, and holds until the next RUN or STEP accept (which clears it to 00) or CLEAR.
REQ-030 done is asserted in the cycle after the terminating retire edge.
REQ-031 core_en is 0 in IDLE and HALTED.

Reset
REQ-032 While rst = 1, on each edge: state IDLE, core_en 0, core_rst 1, busy 0, halted 0, halt_cause 00, insn_count 0, done 0, latched limit 0.
REQ-033 core_rst stays 1 for the first cycle after rst deasserts, then goes to 0.
REQ-034 Reset mid-RUN aborts immediately; no drain and no done pulse.

Verification
REQ-035 RUN with run_limit = 3; retires with PC 0x0003, 0x0006, 0x0009 -> third retire gives IDLE, halt_cause 11, insn_count 3, done pulse, core_en 0.
REQ-036 STEP from IDLE; retire with PC 0x0010 -> IDLE, insn_count +1, cause 00, cmd_ready 0 until the retire.
REQ-037 RUN with limit 0; retire with PC 0x8000 -> HALTED, cause 10; a following RUN is accepted with no effect; CLEAR -> IDLE, count 0, one core_rst pulse.
REQ-038 RUN, then STOP mid-instruction -> DRAIN with core_en 1 and cmd_ready 0; next retire with PC 0x0020 -> IDLE, cause 01.
REQ-039 RUN with limit 1 and STOP accepted on the same retire edge -> cause 11; a NEG_PC retire with limit hit -> cause 10.
REQ-040 Assert rst for 1 cycle mid-RUN -> all outputs at reset values, core_rst high for 2 cycles in total, no done pulse.
